hash_core_arbiter: RTL and testbench

- Shares one lightHashDES-style byte-serial hash core among N_REQ requesters.
- Round-robin arbitration picks the next requester. The block then streams that requester's bytes into the core and returns the 32-bit digest to it with a one-cycle done pulse.
- Sits between the message sources and the single hash core. It is the only driver of the core's input pins.

---
 rtl/hash_core_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_hash_core_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hash_core_arbiter.sv
// Round-robin arbiter that time-shares one byte-serial hash core among N_REQ requesters.
// Streams the granted requester's message into the core and returns the digest with a done pulse.
module hash_core_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned LEN_W = 64,
  localparam int unsigned ID_W = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*LEN_W-1:0] req_len,
  input  logic [N_REQ*8-1:0]     byte_data,
  input  logic [N_REQ-1:0]       byte_valid,
  output logic [N_REQ-1:0]       byte_ready,
  output logic [N_REQ-1:0]       done,
  output logic [31:0]            digest_out,
  output logic [ID_W-1:0]        grant_id,
  output logic                   busy,
  output logic [7:0]             core_M,
  output logic                   core_M_valid,
  output logic [LEN_W-1:0]       core_len,
  input  logic                   core_hash_ready,
  input  logic [31:0]            core_digest
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] GRANT  = 3'd1;
  localparam logic [2:0] ZERO   = 3'd2;
  localparam logic [2:0] STREAM = 3'd3;
  localparam logic [2:0] WAIT   = 3'd4;
  localparam logic [2:0] DONE   = 3'd5;

  logic [2:0]       state_q, state_d;
  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic [ID_W-1:0]  grant_q, grant_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             seen_low_q, seen_low_d;
  logic             aborted_q, aborted_d;
  logic [N_REQ-1:0] done_q, done_d;
  logic             busy_q, busy_d;
  logic [31:0]      digest_q, digest_d;
  logic [7:0]       m_q, m_d;
  logic             mv_q, mv_d;
  logic [N_REQ-1:0] ready;

  logic [LEN_W-1:0] len_arr  [N_REQ];
  logic [7:0]       data_arr [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign len_arr[g]  = req_len[g*LEN_W +: LEN_W];
    assign data_arr[g] = byte_data[g*8 +: 8];
  end

  // First requester after the last owner, wrapping around.
  logic [ID_W-1:0] pick;
  logic [ID_W-1:0] idx;
  logic            found;

  always_comb begin
    pick  = '0;
    idx   = '0;
    found = 1'b0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      idx = ID_W'((32'(ptr_q) + k) % N_REQ);
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    grant_d    = grant_q;
    rem_d      = rem_q;
    len_d      = len_q;
    seen_low_d = seen_low_q;
    aborted_d  = aborted_q;
    done_d     = '0;
    busy_d     = busy_q;
    digest_d   = digest_q;
    m_d        = m_q;
    mv_d       = 1'b0;
    ready      = '0;
    case (state_q)
      IDLE: begin
        if (found) begin
          grant_d    = pick;
          ptr_d      = pick;
          rem_d      = len_arr[pick];
          len_d      = len_arr[pick];
          busy_d     = 1'b1;
          seen_low_d = 1'b0;
          aborted_d  = 1'b0;
          state_d    = GRANT;
        end
      end
      GRANT: begin
        if (rem_q == '0) begin
          // Empty message: one dummy byte starts the core without hashing anything.
          m_d     = 8'h00;
          mv_d    = 1'b1;
          state_d = ZERO;
        end else begin
          state_d = STREAM;
        end
      end
      ZERO: state_d = WAIT;
      STREAM: begin
        if (aborted_q || !req[grant_q]) begin
          // Owner walked away: pad out the promised length so the core still finishes.
          aborted_d = 1'b1;
          m_d       = 8'h00;
          mv_d      = 1'b1;
          rem_d     = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) state_d = WAIT;
        end else begin
          ready[grant_q] = 1'b1;
          if (byte_valid[grant_q]) begin
            m_d   = data_arr[grant_q];
            mv_d  = 1'b1;
            rem_d = rem_q - LEN_W'(1);
            if (rem_q == LEN_W'(1)) state_d = WAIT;
          end
        end
      end
      WAIT: begin
        // A high level is only trusted after it was seen low, so the previous digest is skipped.
        if (!core_hash_ready) begin
          seen_low_d = 1'b1;
        end else if (seen_low_q) begin
          state_d = DONE;
          if (!aborted_q) begin
            digest_d        = core_digest;
            done_d[grant_q] = 1'b1;
          end
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ptr_q      <= ID_W'(N_REQ - 1);
      grant_q    <= '0;
      rem_q      <= '0;
      len_q      <= '0;
      seen_low_q <= 1'b0;
      aborted_q  <= 1'b0;
      done_q     <= '0;
      busy_q     <= 1'b0;
      digest_q   <= '0;
      m_q        <= '0;
      mv_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      grant_q    <= grant_d;
      rem_q      <= rem_d;
      len_q      <= len_d;
      seen_low_q <= seen_low_d;
      aborted_q  <= aborted_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      digest_q   <= digest_d;
      m_q        <= m_d;
      mv_q       <= mv_d;
    end
  end

  assign byte_ready   = ready;
  assign done         = done_q;
  assign digest_out   = digest_q;
  assign grant_id     = grant_q;
  assign busy         = busy_q;
  assign core_M       = m_q;
  assign core_M_valid = mv_q;
  assign core_len     = len_q;

endmodule

// File: tb/tb_hash_core_arbiter.sv
// Randomized bench for hash_core_arbiter with a stand-in byte-serial core and a
// round-robin / digest reference model.
module tb_hash_core_arbiter;
  localparam int N  = 4;
  localparam int LW = 64;
  localparam logic [31:0] IV = 32'hB4D92C3F;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req, byte_valid, byte_ready, done;
  logic [N*LW-1:0] req_len;
  logic [N*8-1:0]  byte_data;
  logic [31:0]     digest_out, core_digest;
  logic [1:0]      grant_id;
  logic            busy, core_M_valid, core_hash_ready;
  logic [7:0]      core_M;
  logic [LW-1:0]   core_len;

  always #5 clk = ~clk;

  hash_core_arbiter #(.N_REQ(N), .LEN_W(LW)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_len(req_len), .byte_data(byte_data),
    .byte_valid(byte_valid), .byte_ready(byte_ready), .done(done), .digest_out(digest_out),
    .grant_id(grant_id), .busy(busy), .core_M(core_M), .core_M_valid(core_M_valid),
    .core_len(core_len), .core_hash_ready(core_hash_ready), .core_digest(core_digest)
  );

  function automatic logic [31:0] mix(input logic [31:0] h, input logic [7:0] b);
    return (h ^ {24'h0, b}) * 32'h01000193;
  endfunction

  // Stand-in core: hashes core_len bytes, drops ready when the last byte lands, raises it later.
  int          c_state;
  logic [63:0] c_len, c_cnt;
  logic [31:0] c_acc;
  int          c_delay;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_state <= 0; c_len <= '0; c_cnt <= '0; c_acc <= IV; c_delay <= 0;
      core_hash_ready <= 1'b0; core_digest <= '0;
    end else begin
      case (c_state)
        0: if (core_M_valid) begin
          c_len <= core_len;
          if (core_len <= 1) begin
            c_acc <= (core_len == 0) ? IV : mix(IV, core_M);
            c_state <= 2; c_delay <= 3; core_hash_ready <= 1'b0;
          end else begin
            c_acc <= mix(IV, core_M); c_cnt <= 1; c_state <= 1;
          end
        end
        1: if (core_M_valid) begin
          c_acc <= mix(c_acc, core_M); c_cnt <= c_cnt + 1;
          if (c_cnt + 1 == c_len) begin
            c_state <= 2; c_delay <= 3; core_hash_ready <= 1'b0;
          end
        end
        default: if (c_delay == 0) begin
          core_hash_ready <= 1'b1; core_digest <= c_acc; c_state <= 0;
        end else c_delay <= c_delay - 1;
      endcase
    end
  end

  int nvalid = 0, zero_bad = 0;
  always @(posedge clk) begin
    if (core_M_valid) nvalid <= nvalid + 1;
    if (core_M_valid && c_state == 0 && core_len == 0 && core_M != 8'h00) zero_bad <= zero_bad + 1;
  end

  // Requester-side state and reference model.
  logic [7:0]  mem [N][16];
  int          len [N], ptr [N], reload [N], abort_after [N], vmode [N];
  logic [15:0] vpat [N];
  logic [N-1:0] fire_pend, pending;
  int          last_owner, done_events, n_checks, n_fail;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_digest(input int r);
    logic [31:0] h;
    h = IV;
    for (int k = 0; k < len[r]; k++) h = mix(h, mem[r][k]);
    return h;
  endfunction

  task automatic load(input int r, input int l, input int vm);
    len[r] = l; ptr[r] = 0; vmode[r] = vm;
    for (int k = 0; k < 16; k++) mem[r][k] = 8'($urandom);
    req[r] = 1'b1; pending[r] = 1'b1;
    req_len[r*LW +: LW] = LW'(l);
  endtask

  task automatic step();
    int exp_o;
    @(negedge clk);
    for (int i = 0; i < N; i++) if (fire_pend[i]) ptr[i]++;
    for (int i = 0; i < N; i++) if (req[i] && ptr[i] >= abort_after[i]) req[i] = 1'b0;
    if (done != '0) begin
      exp_o = -1;
      for (int k = 1; k <= N; k++)
        if (exp_o < 0 && pending[(last_owner + k) % N]) exp_o = (last_owner + k) % N;
      check_eq("done_onehot", done, (exp_o < 0) ? 0 : (1 << exp_o));
      if (exp_o >= 0) begin
        check_eq("grant_id", grant_id, exp_o);
        check_eq("digest", digest_out, ref_digest(exp_o));
        check_eq("core_len", core_len, len[exp_o]);
        last_owner = exp_o;
        done_events++;
        if (reload[exp_o] > 0) begin
          reload[exp_o]--;
          load(exp_o, len[exp_o], vmode[exp_o]);
        end else begin
          req[exp_o] = 1'b0; pending[exp_o] = 1'b0;
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      logic v;
      byte_data[i*8 +: 8] = (ptr[i] < 16) ? mem[i][ptr[i]] : 8'h00;
      case (vmode[i])
        0:       v = 1'b1;
        1:       v = 1'($urandom);
        default: v = vpat[i][0];
      endcase
      if (vmode[i] == 2 && byte_ready[i]) vpat[i] = {1'b1, vpat[i][15:1]};
      byte_valid[i] = v && (ptr[i] < len[i]);
    end
    #1;
    fire_pend = byte_valid & byte_ready;
  endtask

  task automatic run_jobs(input int target, input int budget);
    int n;
    n = 0;
    while (n < budget && !(done_events >= target && !busy)) begin step(); n++; end
    check_eq("jobs_done", done_events, target);
    check_eq("busy_idle", busy, 0);
  endtask

  task automatic wait_busy(input logic lvl, input int budget);
    int n;
    n = 0;
    while (busy !== lvl && n < budget) begin step(); n++; end
    check_eq("busy_level", busy, lvl);
  endtask

  task automatic check_reset();
    check_eq("rst_byte_ready", byte_ready, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_core_valid", core_M_valid, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_digest", digest_out, 0);
    check_eq("rst_core_M", core_M, 0);
    check_eq("rst_core_len", core_len, 0);
    check_eq("rst_grant_id", grant_id, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int nv0, d0;
    logic [31:0] dig0, pad_ref;
    req = '0; byte_valid = '0; byte_data = '0; req_len = '0;
    for (int i = 0; i < N; i++) begin
      len[i] = 0; ptr[i] = 0; reload[i] = 0; abort_after[i] = 99; vmode[i] = 0; vpat[i] = '1;
      for (int k = 0; k < 16; k++) mem[i][k] = 8'h00;
    end
    pending = '0; fire_pend = '0; last_owner = N - 1; done_events = 0; n_checks = 0; n_fail = 0;

    repeat (3) @(negedge clk);
    check_reset();
    rst_n = 1'b1;

    // "abc" from requester 1
    nv0 = nvalid;
    load(1, 3, 1);
    mem[1][0] = 8'h61; mem[1][1] = 8'h62; mem[1][2] = 8'h63;
    run_jobs(1, 300);
    check_eq("abc_bytes", nvalid - nv0, 3);
    check_eq("abc_digest", digest_out, mix(mix(mix(IV, 8'h61), 8'h62), 8'h63));

    // Zero-length message from requester 2
    nv0 = nvalid;
    load(2, 0, 0);
    run_jobs(2, 300);
    check_eq("zero_bytes", nvalid - nv0, 1);
    check_eq("zero_byte_value", zero_bad, 0);
    check_eq("zero_digest", digest_out, 32'hB4D92C3F);

    // Stalled stream from requester 0
    nv0 = nvalid;
    load(0, 4, 2);
    vpat[0] = {9'h1FF, 7'b1011001};
    run_jobs(3, 300);
    check_eq("stall_bytes", nvalid - nv0, 4);

    // All four requesting; requester 0 comes back for a second job
    nv0 = nvalid;
    for (int i = 0; i < N; i++) load(i, 2, 1);
    reload[0] = 1;
    run_jobs(8, 1000);
    check_eq("rr_bytes", nvalid - nv0, 10);

    // Requester 3 abandons after 2 of 5 bytes
    dig0 = digest_out; d0 = done_events; nv0 = nvalid;
    abort_after[3] = 2;
    load(3, 5, 0);
    wait_busy(1'b1, 50);
    wait_busy(1'b0, 300);
    pad_ref = mix(mix(mix(mix(mix(IV, mem[3][0]), mem[3][1]), 8'h00), 8'h00), 8'h00);
    check_eq("abort_bytes", nvalid - nv0, 5);
    check_eq("abort_no_done", done_events, d0);
    check_eq("abort_digest_kept", digest_out, dig0);
    check_eq("abort_pad_hash", core_digest, pad_ref);
    pending[3] = 1'b0; last_owner = 3; abort_after[3] = 99;
    load(1, 3, 1);
    run_jobs(d0 + 1, 300);

    // Reset in the middle of a stream
    load(1, 8, 0);
    wait_busy(1'b1, 50);
    repeat (3) step();
    d0 = done_events;
    #2 rst_n = 1'b0;
    #1 check_reset();
    req = '0; byte_valid = '0; byte_data = '0; pending = '0; fire_pend = '0;
    last_owner = N - 1;
    for (int i = 0; i < N; i++) begin ptr[i] = 0; len[i] = 0; end
    @(negedge clk);
    @(negedge clk) rst_n = 1'b1;
    load(2, 1, 1);
    run_jobs(d0 + 1, 300);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
